// File: rtl/im_loader_if.sv
// Byte-stream and instruction-memory write signals shared by the boot loader
// and whatever feeds it / consumes its writes.
interface im_loader_if #(
    parameter int AW = 8
);
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          en;
    logic [31:0]   outer_inst;
    logic [AW-1:0] imwaddr;
    logic          core_rst_n;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, en, outer_inst, imwaddr, core_rst_n, done, err, err_code
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, en, outer_inst, imwaddr, core_rst_n, done, err, err_code
    );
endinterface

// File: rtl/im_loader.sv
// Boot-time loader: turns a framed big-endian byte stream into instruction-memory
// writes, checks an XOR checksum and only then lets the CPU core out of reset.
module im_loader #(
    parameter int IM_DEPTH = 256,
    parameter int TIMEOUT  = 1_000_000,
    parameter int AW       = $clog2(IM_DEPTH)
) (
    input  logic       cpu_clk_50M,
    input  logic       cpu_rst_n,
    im_loader_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {HDR, DATA, CSUM, RUN, ERR} state_e;

    state_e        state_q,    state_d;
    logic          started_q,  started_d;
    logic [15:0]   n_q,        n_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   shift_q,    shift_d;
    logic [AW:0]   word_cnt_q, word_cnt_d;
    logic [7:0]    xor_q,      xor_d;
    logic [TW-1:0] tmo_q,      tmo_d;
    logic          en_q,       en_d;
    logic [31:0]   inst_q,     inst_d;
    logic [AW-1:0] waddr_q,    waddr_d;
    logic [1:0]    err_code_q, err_code_d;

    logic        active;
    logic        accept;
    logic [15:0] n_full;

    assign active = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
    assign accept = active && bus.rx_valid;
    assign n_full = {n_q[15:8], bus.rx_data};

    always_comb begin
        state_d    = state_q;
        started_d  = started_q;
        n_d        = n_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        word_cnt_d = word_cnt_q;
        xor_d      = xor_q;
        tmo_d      = tmo_q;
        en_d       = 1'b0;
        inst_d     = inst_q;
        waddr_d    = waddr_q;
        err_code_d = err_code_q;

        if (accept) begin
            tmo_d = '0;
            case (state_q)
                HDR: begin
                    xor_d = xor_q ^ bus.rx_data;
                    if (!started_q) begin
                        started_d = 1'b1;
                        n_d       = {bus.rx_data, 8'h00};
                    end else begin
                        n_d = n_full;
                        if (n_full == 16'd0 || {16'd0, n_full} > 32'(IM_DEPTH)) begin
                            state_d    = ERR;
                            err_code_d = 2'd1;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    xor_d      = xor_q ^ bus.rx_data;
                    shift_d    = {shift_q[15:0], bus.rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        inst_d     = {shift_q, bus.rx_data};
                        waddr_d    = word_cnt_q[AW-1:0];
                        en_d       = 1'b1;
                        word_cnt_d = word_cnt_q + (AW+1)'(1);
                        // n_q was bounded by IM_DEPTH in HDR, so the truncation is exact
                        if (word_cnt_d == n_q[AW:0]) begin
                            state_d = CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (bus.rx_data == xor_q) begin
                        state_d = RUN;
                    end else begin
                        state_d    = ERR;
                        err_code_d = 2'd3;
                    end
                end
                default: ;
            endcase
        end else if (started_q && active) begin
            // A byte arriving on the expiry edge wins, hence this sits in the else
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d    = ERR;
                err_code_d = 2'd2;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state_q    <= HDR;
            started_q  <= 1'b0;
            n_q        <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            word_cnt_q <= '0;
            xor_q      <= '0;
            tmo_q      <= '0;
            en_q       <= 1'b0;
            inst_q     <= '0;
            waddr_q    <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            started_q  <= started_d;
            n_q        <= n_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            word_cnt_q <= word_cnt_d;
            xor_q      <= xor_d;
            tmo_q      <= tmo_d;
            en_q       <= en_d;
            inst_q     <= inst_d;
            waddr_q    <= waddr_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.rx_ready   = active;
    assign bus.en         = en_q;
    assign bus.outer_inst = inst_q;
    assign bus.imwaddr    = waddr_q;
    assign bus.core_rst_n = (state_q == RUN);
    assign bus.done       = (state_q == RUN);
    assign bus.err        = (state_q == ERR);
    assign bus.err_code   = err_code_q;
endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed frames from the test plan plus
// randomized frames compared against a frame-level reference model.
module tb_im_loader;
    localparam int IM_DEPTH = 256;
    localparam int TIMEOUT  = 16;
    localparam int AW       = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    im_loader_if #(.AW(AW)) bus ();

    im_loader #(.IM_DEPTH(IM_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .cpu_clk_50M(clk),
        .cpu_rst_n  (rst_n),
        .bus        (bus)
    );

    logic [7:0] frame_q[$];
    int         gap_q[$];
    int         acc_cyc[$];
    int         n_acc;
    int         mon_addr[$];
    int         mon_inst[$];
    int         mon_cyc[$];
    int         e_addr[$];
    int         e_inst[$];
    int         e_idx[$];
    int         e_acc;
    int         e_code;
    int         e_done;

    always @(negedge clk) begin
        if (bus.en === 1'b1) begin
            mon_addr.push_back(int'(bus.imwaddr));
            mon_inst.push_back(int'(bus.outer_inst));
            mon_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_en", 32'(bus.en), 32'd0);
        check("rst_inst", bus.outer_inst, 32'd0);
        check("rst_waddr", 32'(bus.imwaddr), 32'd0);
        check("rst_core_rst_n", 32'(bus.core_rst_n), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_err_code", 32'(bus.err_code), 32'd0);
    endtask

    // Frame-level reference: walks the byte list by frame position, not by cycles.
    task automatic model();
        int         n;
        logic [7:0] x;
        logic [7:0] b;
        logic [31:0] w;
        e_addr.delete(); e_inst.delete(); e_idx.delete();
        e_acc = 0; e_code = 0; e_done = 0; n = 0; x = 8'h00; w = 32'h0;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i > 0 && gap_q[i] >= TIMEOUT) begin
                e_code = 2;
                return;
            end
            e_acc++;
            b = frame_q[i];
            if (i < 2) begin
                n = n * 256 + int'(b);
                x = x ^ b;
                if (i == 1 && (n == 0 || n > IM_DEPTH)) begin
                    e_code = 1;
                    return;
                end
            end else if (i < 2 + 4 * n) begin
                x = x ^ b;
                w = {w[23:0], b};
                if ((i - 2) % 4 == 3) begin
                    e_addr.push_back((i - 2) / 4);
                    e_inst.push_back(int'(w));
                    e_idx.push_back(i);
                end
            end else begin
                if (b == x) e_done = 1;
                else        e_code = 3;
                return;
            end
        end
        if (e_acc > 0) e_code = 2;
    endtask

    task automatic drive();
        acc_cyc.delete(); mon_addr.delete(); mon_inst.delete(); mon_cyc.delete();
        n_acc = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (gap_q[i] > 0) begin
                bus.rx_valid = 1'b0;
                repeat (gap_q[i]) begin @(posedge clk); #1; end
            end
            if (bus.rx_ready !== 1'b1) break;
            bus.rx_valid = 1'b1;
            bus.rx_data  = frame_q[i];
            @(posedge clk); #1;
            acc_cyc.push_back(cyc);
            n_acc++;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_result(input string tag);
        model();
        repeat (TIMEOUT + 4) @(posedge clk);
        #1;
        check({tag, "_accepted"}, n_acc, e_acc);
        check({tag, "_nwrites"}, mon_addr.size(), e_addr.size());
        for (int i = 0; i < e_addr.size() && i < mon_addr.size(); i++) begin
            check({tag, "_waddr"}, mon_addr[i], e_addr[i]);
            check({tag, "_inst"}, mon_inst[i], e_inst[i]);
            if (e_idx[i] < acc_cyc.size())
                check({tag, "_en_cycle"}, mon_cyc[i], acc_cyc[e_idx[i]]);
        end
        check({tag, "_done"}, 32'(bus.done), e_done);
        check({tag, "_core_rst_n"}, 32'(bus.core_rst_n), e_done);
        check({tag, "_err"}, 32'(bus.err), (e_code != 0) ? 1 : 0);
        check({tag, "_err_code"}, 32'(bus.err_code), e_code);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), (e_done == 1 || e_code != 0) ? 0 : 1);
    endtask

    task automatic zero_gaps();
        gap_q.delete();
        for (int i = 0; i < frame_q.size(); i++) gap_q.push_back(0);
    endtask

    task automatic build_frame(input int n, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        x = 8'h00;
        b = 8'(n >> 8); frame_q.push_back(b); x = x ^ b;
        b = 8'(n);      frame_q.push_back(b); x = x ^ b;
        for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            x = x ^ b;
        end
        frame_q.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
        zero_gaps();
    endtask

    task automatic good_frame(input logic [7:0] last);
        frame_q = {8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01,
                   8'h34, 8'h21, 8'h00, 8'h05, last};
        zero_gaps();
    endtask

    initial begin
        int n;
        int mode;
        int drop;
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        // Good load, back-to-back, with known words and done one cycle after 0x2E
        do_reset();
        good_frame(8'h2E);
        drive();
        check("good_done_now", 32'(bus.done), 32'd1);
        check("good_core_now", 32'(bus.core_rst_n), 32'd1);
        check("good_ready_now", 32'(bus.rx_ready), 32'd0);
        if (mon_inst.size() == 2) begin
            check("good_word0", mon_inst[0], 32'h3C010001);
            check("good_word1", mon_inst[1], 32'h34210005);
        end else begin
            check("good_word_count", mon_inst.size(), 2);
        end
        check_result("good");

        do_reset();
        good_frame(8'h2F);
        drive();
        check_result("badcsum");

        do_reset();
        frame_q = {8'h00, 8'h00, 8'h11, 8'h22};
        zero_gaps();
        drive();
        check_result("len0");

        do_reset();
        frame_q = {8'h01, 8'h01, 8'h11, 8'h22};
        zero_gaps();
        drive();
        check_result("len257");

        // Timeout lands exactly TIMEOUT edges after the last accepted byte
        do_reset();
        frame_q = {8'h00, 8'h01, 8'h3C};
        zero_gaps();
        drive();
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(posedge clk); #1;
            if (k == TIMEOUT - 1) check("tmo_early_err", 32'(bus.err), 32'd0);
            if (k == TIMEOUT) begin
                check("tmo_err", 32'(bus.err), 32'd1);
                check("tmo_code", 32'(bus.err_code), 32'd2);
            end
        end
        check_result("tmo");

        do_reset();
        repeat (TIMEOUT * 3) @(posedge clk);
        #1;
        check("idle_err", 32'(bus.err), 32'd0);
        check("idle_ready", 32'(bus.rx_ready), 32'd1);

        do_reset();
        good_frame(8'h2E);
        for (int i = 0; i < gap_q.size(); i++) gap_q[i] = $urandom_range(0, TIMEOUT - 1);
        drive();
        check_result("gapped");

        // Reset mid-DATA discards the partial load
        do_reset();
        good_frame(8'h2E);
        frame_q = frame_q[0:4];
        zero_gaps();
        drive();
        check("mid_writes", mon_addr.size(), 0);
        do_reset();
        good_frame(8'h2E);
        drive();
        check_result("after_mid_reset");

        do_reset();
        build_frame(IM_DEPTH, 1'b0);
        drive();
        check_result("maxlen");

        for (int t = 0; t < 30; t++) begin
            mode = $urandom_range(0, 9);
            n    = $urandom_range(1, 6);
            if (mode == 0) n = 0;
            if (mode == 1) n = IM_DEPTH + 1 + $urandom_range(0, 3);
            build_frame(n, mode == 2);
            for (int i = 0; i < gap_q.size(); i++) gap_q[i] = $urandom_range(0, 3);
            gap_q[0] = $urandom_range(0, 2 * TIMEOUT);
            if (mode == 3) gap_q[$urandom_range(1, gap_q.size() - 1)] = TIMEOUT + $urandom_range(0, 3);
            if (mode == 4) begin
                drop = $urandom_range(1, frame_q.size() - 1);
                repeat (drop) begin
                    void'(frame_q.pop_back());
                    void'(gap_q.pop_back());
                end
            end
            do_reset();
            drive();
            check_result("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
